// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared sizing and FSM encoding for the LEGv8 issue/hazard controller.
package hazard_scoreboard_ctrl_pkg;

    localparam int unsigned NREGS    = 32;
    localparam int unsigned ADDRW    = 5;
    localparam int unsigned CNTW     = 2;
    localparam int unsigned ZERO_REG = 31;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode/writeback/execute signals seen by the issue controller, plus its stall/flush outputs.
interface hazard_scoreboard_ctrl_if #(
    parameter int unsigned PERFW = 16
);
    import hazard_scoreboard_ctrl_pkg::*;

    logic             id_valid;
    logic [ADDRW-1:0] id_rn;
    logic [ADDRW-1:0] id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [ADDRW-1:0] id_rd;
    logic             id_regwrite;
    logic             wb_valid;
    logic [ADDRW-1:0] wb_rd;
    logic             ex_pcsrc;
    logic             issue;
    logic             stall_if;
    logic             flush_ifid;
    logic             flush_idex;
    logic [NREGS-1:0] busy_mask;
    logic [PERFW-1:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_regwrite,
        output wb_valid, wb_rd, ex_pcsrc,
        input  issue, stall_if, flush_ifid, flush_idex, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_regwrite,
        input  wb_valid, wb_rd, ex_pcsrc,
        output issue, stall_if, flush_ifid, flush_idex, busy_mask, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_ctrl_sb_counter_bank.sv
// Per-register pending-write counters; XZR has no counter and is never busy.
module sb_counter_bank
    import hazard_scoreboard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic [ADDRW-1:0] inc_idx_i,
    input  logic             wb_dec_i,
    input  logic [ADDRW-1:0] wb_idx_i,
    input  logic             sq_dec_i,
    input  logic [ADDRW-1:0] sq_idx_i,
    output logic [NREGS-1:0] busy_o
);

    localparam logic [CNTW-1:0] CntMax = '1;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign busy_o[r] = 1'b0;
        end else begin : g_cnt
            logic [CNTW-1:0] cnt_d, cnt_q;
            logic [CNTW+1:0] up, dec;

            // Writeback and squash can both hit one register, so dec spans 0..2.
            always_comb begin
                up  = {2'b00, cnt_q} + (CNTW+2)'(inc_i && (inc_idx_i == ADDRW'(r)));
                dec = (CNTW+2)'(wb_dec_i && (wb_idx_i == ADDRW'(r)))
                    + (CNTW+2)'(sq_dec_i && (sq_idx_i == ADDRW'(r)));
                if (up < dec) begin
                    cnt_d = '0;
                end else if ((up - dec) > {2'b00, CntMax}) begin
                    cnt_d = CntMax;
                end else begin
                    cnt_d = CNTW'(up - dec);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    assert (up >= dec);
                    assert ((up - dec) <= {2'b00, CntMax});
                end
            end

            assign busy_o[r] = (cnt_q != '0);
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Issue controller: RAW stall via pending-write scoreboard, taken-branch flush sequencing.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned PERFW        = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard_scoreboard_ctrl_if.slave bus
);

    localparam int unsigned FCNTW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

    state_e           state_d, state_q;
    logic [FCNTW-1:0] fcnt_d, fcnt_q;
    logic             slot_valid_d, slot_valid_q;
    logic [ADDRW-1:0] slot_rd_d, slot_rd_q;
    logic [PERFW-1:0] stall_cnt_d, stall_cnt_q;

    logic [NREGS-1:0] busy;
    logic             hazard, rn_hz, rm_hz;
    logic             issue, stall_if, flush_ifid, flush_idex, squash;

    assign rn_hz  = bus.id_use_rn && (bus.id_rn != ADDRW'(ZERO_REG)) && busy[bus.id_rn];
    assign rm_hz  = bus.id_use_rm && (bus.id_rm != ADDRW'(ZERO_REG)) && busy[bus.id_rm];
    assign hazard = bus.id_valid && (rn_hz || rm_hz);

    // The branch cycle is the first bubble; FLUSH supplies the remaining FLUSH_CYCLES-1.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        slot_valid_d = 1'b0;
        slot_rd_d    = slot_rd_q;
        stall_cnt_d  = stall_cnt_q;
        issue        = 1'b0;
        stall_if     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        squash       = 1'b0;
        if (!rst_n) begin
            flush_idex = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.ex_pcsrc) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        squash     = slot_valid_q;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = StFlush;
                            fcnt_d  = FCNTW'(FLUSH_CYCLES - 2);
                        end
                    end else begin
                        issue        = bus.id_valid && !hazard;
                        stall_if     = hazard;
                        flush_idex   = hazard;
                        slot_valid_d = issue && bus.id_regwrite
                                       && (bus.id_rd != ADDRW'(ZERO_REG));
                        slot_rd_d    = bus.id_rd;
                        if (hazard && (stall_cnt_q != '1)) begin
                            stall_cnt_d = stall_cnt_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    fcnt_d     = fcnt_q - 1'b1;
                    if (fcnt_q == '0) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            fcnt_q       <= '0;
            slot_valid_q <= 1'b0;
            slot_rd_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            slot_valid_q <= slot_valid_d;
            slot_rd_q    <= slot_rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    sb_counter_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (issue && bus.id_regwrite && (bus.id_rd != ADDRW'(ZERO_REG))),
        .inc_idx_i (bus.id_rd),
        .wb_dec_i  (bus.wb_valid),
        .wb_idx_i  (bus.wb_rd),
        .sq_dec_i  (squash),
        .sq_idx_i  (slot_rd_q),
        .busy_o    (busy)
    );

    assign bus.issue       = issue;
    assign bus.stall_if    = stall_if;
    assign bus.flush_ifid  = flush_ifid;
    assign bus.flush_idex  = flush_idex;
    assign bus.busy_mask   = rst_n ? busy : '0;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl; outputs sampled mid-cycle, inputs driven after posedge.
module tb_hazard_scoreboard_ctrl;
    import hazard_scoreboard_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_scoreboard_ctrl_if #(.PERFW(16)) bus ();

    hazard_scoreboard_ctrl #(
        .FLUSH_CYCLES (2),
        .PERFW        (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {issue, stall_if, flush_ifid, flush_idex}
    logic [3:0] outs;
    assign outs = {bus.issue, bus.stall_if, bus.flush_ifid, bus.flush_idex};

    localparam logic [3:0] O_ISSUE = 4'b1000;
    localparam logic [3:0] O_STALL = 4'b0101;
    localparam logic [3:0] O_FLUSH = 4'b0011;
    localparam logic [3:0] O_RESET = 4'b0001;
    localparam logic [3:0] O_IDLE  = 4'b0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_rn       = '0;
        bus.id_rm       = '0;
        bus.id_use_rn   = 1'b0;
        bus.id_use_rm   = 1'b0;
        bus.id_rd       = '0;
        bus.id_regwrite = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.ex_pcsrc    = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rn, input logic use_rn, input logic [4:0] rm,
                          input logic use_rm, input logic [4:0] rd, input logic regwrite);
        bus.id_valid    = 1'b1;
        bus.id_rn       = rn;
        bus.id_use_rn   = use_rn;
        bus.id_rm       = rm;
        bus.id_use_rm   = use_rm;
        bus.id_rd       = rd;
        bus.id_regwrite = regwrite;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        #4;
        n_checks++;
        if (outs !== O_RESET) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", outs, O_RESET);
        end
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h want 0", bus.busy_mask);
        end
        n_checks++;
        if (bus.stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_count: got %0d want 0", bus.stall_count);
        end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_raw_stall();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL raw_first_issue: got %b want %b", outs, O_ISSUE);
        end
        tick();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            bus.wb_valid = (c == 2);
            bus.wb_rd    = 5'd1;
            #4;
            n_checks++;
            if (outs !== O_STALL) begin
                n_fail++;
                $display("FAIL raw_stall_cyc%0d: got %b want %b", c, outs, O_STALL);
            end
            tick();
        end
        bus.wb_valid = 1'b0;
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL raw_issue_after_retire: got %b want %b", outs, O_ISSUE);
        end
        n_checks++;
        if (bus.stall_count !== 16'd3) begin
            n_fail++;
            $display("FAIL raw_stall_count: got %0d want 3", bus.stall_count);
        end
        tick();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd2;
        tick();
        idle();
        #4;
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL raw_busy_clear: got %h want 0", bus.busy_mask);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1);
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL xzr_write_issue: got %b want %b", outs, O_ISSUE);
        end
        tick();
        set_id(5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1);
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL xzr_read_no_stall: got %b want %b", outs, O_ISSUE);
        end
        tick();
        idle();
        #4;
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL xzr_busy: got %h want 0", bus.busy_mask);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
            #4;
            n_checks++;
            if (outs !== O_ISSUE) begin
                n_fail++;
                $display("FAIL b2b_issue%0d: got %b want %b", i, outs, O_ISSUE);
            end
            tick();
        end
        set_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_checks++;
            if (outs !== O_STALL || bus.busy_mask[5] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_pending%0d: got outs %b busy5 %b want %b 1",
                         i, outs, bus.busy_mask[5], O_STALL);
            end
            tick();
        end
        bus.wb_valid = 1'b0;
        #4;
        n_checks++;
        if (outs !== O_ISSUE || bus.busy_mask[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: got outs %b busy5 %b want %b 0",
                     outs, bus.busy_mask[5], O_ISSUE);
        end
        n_checks++;
        if (bus.stall_count !== 16'd6) begin
            n_fail++;
            $display("FAIL b2b_stall_count: got %0d want 6", bus.stall_count);
        end
        tick();
        idle();
    endtask

    task automatic test_branch_flush();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL br_issue_x7: got %b want %b", outs, O_ISSUE);
        end
        tick();
        // Hazard on X7 in the same cycle as the taken branch: flush wins.
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        bus.ex_pcsrc = 1'b1;
        #4;
        n_checks++;
        if (outs !== O_FLUSH || bus.busy_mask[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL br_flush_cyc0: got outs %b busy7 %b want %b 1",
                     outs, bus.busy_mask[7], O_FLUSH);
        end
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0);
        #4;
        n_checks++;
        if (outs !== O_FLUSH || bus.busy_mask[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL br_flush_cyc1: got outs %b busy7 %b want %b 0",
                     outs, bus.busy_mask[7], O_FLUSH);
        end
        tick();
        bus.ex_pcsrc = 1'b0;
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL br_back_to_run: got %b want %b", outs, O_ISSUE);
        end
        n_checks++;
        if (bus.stall_count !== 16'd6) begin
            n_fail++;
            $display("FAIL br_stall_count: got %0d want 6", bus.stall_count);
        end
        tick();
        idle();
        #4;
        n_checks++;
        if (outs !== O_IDLE || bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL br_idle: got outs %b busy %h want %b 0", outs, bus.busy_mask, O_IDLE);
        end
        tick();
    endtask

    task automatic test_wb_same_cycle();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL wbsame_issue: got %b want %b", outs, O_ISSUE);
        end
        tick();
        idle();
        #4;
        n_checks++;
        if (bus.busy_mask[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL wbsame_still_busy: got %b want 1", bus.busy_mask[3]);
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        tick();
        idle();
        #4;
        n_checks++;
        if (bus.busy_mask[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL wbsame_retired: got %b want 0", bus.busy_mask[3]);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        tick();
        idle();
        bus.ex_pcsrc = 1'b1;
        tick();
        bus.ex_pcsrc = 1'b0;
        rst_n = 1'b0;
        #4;
        n_checks++;
        if (outs !== O_RESET || bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL rstflush_outs: got outs %b busy %h want %b 0",
                     outs, bus.busy_mask, O_RESET);
        end
        tick();
        rst_n = 1'b1;
        set_id(5'd9, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0);
        #4;
        n_checks++;
        if (outs !== O_ISSUE) begin
            n_fail++;
            $display("FAIL rstflush_run_issue: got %b want %b", outs, O_ISSUE);
        end
        n_checks++;
        if (bus.busy_mask !== 32'h0 || bus.stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rstflush_cleared: got busy %h count %0d want 0 0",
                     bus.busy_mask, bus.stall_count);
        end
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        tick();
        test_reset();
        test_raw_stall();
        test_zero_reg();
        test_back_to_back();
        test_branch_flush();
        test_wb_same_cycle();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
